// File: rtl/instr_fetch_seq_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_seq_if : ROM/decoder-facing bus of the TB4004 fetch sequencer
// Revision 1.0
// ============================================================================
interface instr_fetch_seq_if #(
  parameter int PC_W = 12
);
  logic            hold;
  logic [3:0]      rom_data;
  logic            jump_en;
  logic [PC_W-1:0] jump_addr;
  logic [PC_W-1:0] rom_addr;
  logic            sync;
  logic [2:0]      phase;
  logic [3:0]      opr;
  logic [3:0]      opa;
  logic [7:0]      op2;
  logic            two_byte;
  logic            instr_valid;

  modport master (
    input  hold, rom_data, jump_en, jump_addr,
    output rom_addr, sync, phase, opr, opa, op2, two_byte, instr_valid
  );

  modport slave (
    output hold, rom_data, jump_en, jump_addr,
    input  rom_addr, sync, phase, opr, opa, op2, two_byte, instr_valid
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// instr_fetch_seq : TB4004 8-phase machine-cycle sequencer, PC and byte fetch
// Revision 1.0
// ============================================================================
module instr_fetch_seq #(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  instr_fetch_seq_if.master  bus
);

  typedef enum logic [2:0] {
    A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
    M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
  } phase_t;

  phase_t          r_state;
  phase_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [3:0]      r_hi;
  logic [3:0]      r_opr;
  logic [3:0]      r_opa;
  logic [7:0]      r_op2;
  logic            r_two;
  logic            r_pending;
  logic            r_fired;
  logic            r_instr_valid;
  logic            w_is_two;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= A1;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      A1:      w_next = bus.hold ? A1 : A2;
      A2:      w_next = A3;
      A3:      w_next = M1;
      M1:      w_next = M2;
      M2:      w_next = X1;
      X1:      w_next = X2;
      X2:      w_next = X3;
      X3:      w_next = A1;
      default: w_next = A1;
    endcase
  end

  // Opcode is r_hi, operand low bit is the nibble arriving in M2
  assign w_is_two = (r_hi == 4'h1) || (r_hi == 4'h4) || (r_hi == 4'h5) ||
                    (r_hi == 4'h7) || ((r_hi == 4'h2) && !bus.rom_data[0]);

  // r_fired marks a cycle whose instruction completed; only then may a jump land
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_hi          <= 4'h0;
      r_opr         <= 4'h0;
      r_opa         <= 4'h0;
      r_op2         <= 8'h00;
      r_two         <= 1'b0;
      r_pending     <= 1'b0;
      r_fired       <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        M1: r_hi <= bus.rom_data;
        M2: begin
          if (r_pending) begin
            r_op2         <= {r_hi, bus.rom_data};
            r_instr_valid <= 1'b1;
            r_fired       <= 1'b1;
          end else begin
            r_opr         <= r_hi;
            r_opa         <= bus.rom_data;
            r_op2         <= 8'h00;
            r_two         <= w_is_two;
            r_pending     <= w_is_two;
            r_instr_valid <= !w_is_two;
            r_fired       <= !w_is_two;
          end
        end
        X3: begin
          r_pc    <= (bus.jump_en && r_fired) ? bus.jump_addr : r_pc + 1'b1;
          r_fired <= 1'b0;
          if (r_fired) r_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // sync is held low while reset is asserted even though the FSM sits in A1
  assign bus.sync        = (r_state == A1) && !bus.hold && rst_n;
  assign bus.phase       = r_state;
  assign bus.rom_addr    = r_pc;
  assign bus.opr         = r_opr;
  assign bus.opa         = r_opa;
  assign bus.op2         = r_op2;
  assign bus.two_byte    = r_two;
  assign bus.instr_valid = r_instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_seq : instruction-level reference model vs. instr_fetch_seq
// Revision 1.0
// ============================================================================
module tb_instr_fetch_seq;

  logic clk;
  logic rst_n;
  logic [7:0] mem [0:4095];

  instr_fetch_seq_if #(.PC_W(12)) bus ();

  instr_fetch_seq #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ROM: high nibble in M1, low nibble in M2
  assign bus.rom_data = (bus.phase == 3'd3) ? mem[bus.rom_addr][7:4] :
                        (bus.phase == 3'd4) ? mem[bus.rom_addr][3:0] : 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Instruction-level model state
  logic [11:0] m_pc;
  bit          m_pend;
  bit          m_valid;
  logic [3:0]  m_opr, m_opa;
  logic [7:0]  m_op2;
  bit          m_two;

  function automatic bit is_two_byte(input logic [7:0] b);
    case (b[7:4])
      4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
      4'h2:                   return !b[0];
      default:                return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outs(input int ph, input bit exp_sync);
    check("phase",       16'(bus.phase),       16'(ph));
    check("sync",        16'(bus.sync),        16'(exp_sync));
    check("rom_addr",    16'(bus.rom_addr),    16'(m_pc));
    check("instr_valid", 16'(bus.instr_valid), 16'((ph == 5) && m_valid));
    check("opr",         16'(bus.opr),         16'(m_opr));
    check("opa",         16'(bus.opa),         16'(m_opa));
    check("op2",         16'(bus.op2),         16'(m_op2));
    check("two_byte",    16'(bus.two_byte),    16'(m_two));
  endtask

  task automatic model_reset();
    m_pc = 12'h000; m_pend = 0; m_valid = 0;
    m_opr = 4'h0; m_opa = 4'h0; m_op2 = 8'h00; m_two = 0;
  endtask

  // Called at a falling edge; leaves hold high so the release edge stays in A1
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.hold = 1'b0;
    bus.jump_en = 1'b0;
    #1;
    model_reset();
    check_outs(0, 0);
    @(negedge clk);
    bus.hold = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic run_cycle(input bit jen, input logic [11:0] jaddr, input int nhold,
                           input int abort_at);
    logic [7:0] b;
    m_valid = 0;
    for (int i = 0; i < nhold; i++) begin
      @(negedge clk);
      bus.hold = 1'b1; bus.jump_en = 1'b0; bus.jump_addr = 12'($urandom);
      #1; check_outs(0, 0);
    end
    @(negedge clk);
    bus.hold = 1'b0; bus.jump_en = 1'b0;
    #1; check_outs(0, 1);
    for (int p = 1; p < 8; p++) begin
      @(negedge clk);
      if (p == abort_at) begin
        apply_reset();
        return;
      end
      bus.hold      = 1'($urandom_range(0, 1));
      bus.jump_en   = (p == 7) ? jen : 1'($urandom_range(0, 1));
      bus.jump_addr = (p == 7) ? jaddr : 12'($urandom);
      if (p == 5) begin
        b = mem[m_pc];
        if (m_pend) begin
          m_op2 = b; m_valid = 1;
        end else begin
          m_opr = b[7:4]; m_opa = b[3:0]; m_op2 = 8'h00;
          m_two = is_two_byte(b); m_pend = m_two; m_valid = !m_two;
        end
      end
      #1; check_outs(p, 0);
    end
    m_pc = (jen && m_valid) ? jaddr : m_pc + 12'h001;
    if (m_valid) m_pend = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.hold = 1'b1;
    bus.jump_en = 1'b0;
    bus.jump_addr = 12'h000;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    model_reset();

    // LDM 5 at address 0
    mem[12'h000] = 8'hD5;
    @(negedge clk); apply_reset();
    run_cycle(0, 12'h000, 0, -1);

    // JUN 0x03A at address 1; jump offered on the first byte must be ignored
    mem[12'h001] = 8'h40; mem[12'h002] = 8'h3A;
    run_cycle(1, 12'h555, 0, -1);
    run_cycle(1, 12'h03A, 0, -1);

    // FIM (two-byte) then SRC (one-byte), then jump to the top of ROM
    mem[12'h03A] = 8'h20; mem[12'h03B] = 8'hC3; mem[12'h03C] = 8'h21;
    run_cycle(0, 12'h000, 0, -1);
    run_cycle(0, 12'h000, 0, -1);
    run_cycle(1, 12'hFFF, 0, -1);

    // PC wrap from 0xFFF, self-loop jump, then hold 10 clks in A1
    mem[12'hFFF] = 8'hD0;
    run_cycle(0, 12'h000, 0, -1);
    run_cycle(1, 12'h000, 0, -1);
    run_cycle(0, 12'h000, 10, -1);

    // Randomised programme, jumps and holds
    for (int k = 0; k < 40; k++)
      run_cycle(1'($urandom_range(0, 1)), 12'($urandom), $urandom_range(0, 2), -1);

    // Reset during M2 of a JMS first byte, then a clean refetch from address 0
    mem[12'h000] = 8'h5A; mem[12'h001] = 8'h7E;
    @(negedge clk); apply_reset();
    run_cycle(0, 12'h000, 0, 4);
    run_cycle(0, 12'h000, 0, -1);
    run_cycle(1, 12'h123, 0, -1);
    run_cycle(0, 12'h000, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
